// File: rtl/rom_prefetch.sv
// Sequential ROM byte prefetch queue sitting between the CPU fetch path and the SPI read port.
// Define PREFETCH_STATS_EN to add saturating hit_cnt_o / flush_cnt_o statistics outputs.
module rom_prefetch #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req_i,
    input  logic [AW-1:0] fetch_addr_i,
    output logic          fetch_valid_o,
    output logic [7:0]    fetch_data_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_done_i,
    input  logic [7:0]    mem_data_i,
    output logic          busy_o
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]   hit_cnt_o,
    output logic [15:0]   flush_cnt_o
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PW:0]   cnt_t;
    typedef logic [PW-1:0] ptr_t;

    localparam cnt_t          CntFull = cnt_t'(DEPTH);
    localparam cnt_t          CntOne  = cnt_t'(1);
    localparam ptr_t          PtrOne  = ptr_t'(1);
    localparam logic [AW-1:0] AddrOne = AW'(1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    logic [AW-1:0] ent_addr_q [DEPTH];
    logic [7:0]    ent_data_q [DEPTH];

    ptr_t          rd_ptr_q, rd_ptr_d;
    ptr_t          wr_ptr_q, wr_ptr_d;
    cnt_t          count_q, count_d;

    state_e        state_q;
    logic          mem_req_q;
    logic [AW-1:0] mem_addr_q;
    logic [AW-1:0] next_addr_q;
    logic          stale_q;

    logic          fifo_empty;
    logic          hit;
    logic          miss;
    logic          flush;
    logic          push;
    logic          pop;
    logic          issue;

    assign fifo_empty = (count_q == '0);
    assign hit        = fetch_req_i && !fifo_empty && (ent_addr_q[rd_ptr_q] == fetch_addr_i);
    assign miss       = fetch_req_i && !hit;

    // An empty queue waiting on exactly the requested byte must not throw that byte away.
    assign flush = miss && (!fifo_empty || (mem_req_q && (mem_addr_q != fetch_addr_i)));

    // Returned data is discarded when it belongs to a flushed stream.
    assign push  = (state_q == StWait) && mem_done_i && !stale_q && !flush;
    assign pop   = hit;

    // In idle nothing is outstanding, so the count alone is the occupancy.
    assign issue = (state_q == StIdle) && !flush && (count_q < CntFull);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= mem_addr_q;
            ent_data_q[wr_ptr_q] <= mem_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            next_addr_q <= '0;
            stale_q     <= 1'b0;
        end else begin
            if (flush) begin
                next_addr_q <= fetch_addr_i;
            end
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        mem_addr_q  <= next_addr_q;
                        next_addr_q <= next_addr_q + AddrOne;
                        mem_req_q   <= 1'b1;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (mem_done_i) begin
                        mem_req_q <= 1'b0;
                        stale_q   <= 1'b0;
                        state_q   <= StIdle;
                    end else if (flush) begin
                        stale_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fetch_valid_o = hit;
    assign fetch_data_o  = hit ? ent_data_q[rd_ptr_q] : 8'h00;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign busy_o        = mem_req_q || (count_q != CntFull);

`ifdef PREFETCH_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hit && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt_o   = hit_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_rom_prefetch.sv
// Directed self-checking bench for rom_prefetch (DEPTH=4, AW=16) with a simple SPI ROM responder.
module tb_rom_prefetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_valid;
    logic [7:0]  fetch_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_done;
    logic [7:0]  mem_data;
    logic        busy;
`ifdef PREFETCH_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Responder control: auto-answer two cycles after mem_req, or answer at once on a kick.
    logic        resp_en  = 1'b0;
    int          kick_req = 0;
    int          kick_ack = 0;
    int          wait_cnt = 0;
    logic        req_prev = 1'b0;
    logic [15:0] issued_q [$];

    rom_prefetch #(
        .DEPTH (4),
        .AW    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_req_i   (fetch_req),
        .fetch_addr_i  (fetch_addr),
        .fetch_valid_o (fetch_valid),
        .fetch_data_o  (fetch_data),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_done_i    (mem_done),
        .mem_data_i    (mem_data),
        .busy_o        (busy)
`ifdef PREFETCH_STATS_EN
        ,
        .hit_cnt_o     (hit_cnt),
        .flush_cnt_o   (flush_cnt)
`endif
    );

    function automatic logic [7:0] mem_image(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #1;
        if (mem_done) begin
            mem_done = 1'b0;
        end else if (!rst_n || !mem_req) begin
            wait_cnt = 0;
        end else if (kick_ack != kick_req) begin
            mem_done = 1'b1;
            mem_data = mem_image(mem_addr);
            kick_ack = kick_ack + 1;
            wait_cnt = 0;
        end else if (resp_en) begin
            wait_cnt = wait_cnt + 1;
            if (wait_cnt == 2) begin
                mem_done = 1'b1;
                mem_data = mem_image(mem_addr);
                wait_cnt = 0;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (mem_req && !req_prev) issued_q.push_back(mem_addr);
        req_prev = mem_req;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_full(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: busy still %0b after 60 cycles, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 16'h0000;
        mem_done   = 1'b0;
        mem_data   = 8'h00;
        #1 rst_n = 1'b0;
        @(negedge clk);
        fetch_req = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %0b want 0", mem_req); end
        n_checks++;
        if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fetch_valid: got %0b want 0", fetch_valid); end
        n_checks++;
        if (fetch_data !== 8'h00) begin n_fail++; $display("FAIL rst_fetch_data: got %h want 00", fetch_data); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %0b want 1", busy); end
        fetch_req = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        resp_en = 1'b1;
        issued_q.delete();
    endtask

    task automatic test_fill();
        logic [15:0] exp_a [4];
        exp_a = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
        wait_full("fill_full");
        n_checks++;
        if (issued_q.size() != 4) begin
            n_fail++; $display("FAIL fill_count: got %0d requests want 4", issued_q.size());
        end
        for (int i = 0; i < 4 && i < issued_q.size(); i++) begin
            n_checks++;
            if (issued_q[i] !== exp_a[i]) begin
                n_fail++; $display("FAIL fill_addr[%0d]: got %h want %h", i, issued_q[i], exp_a[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_idle: mem_req %0b want 0", mem_req); end
        end
    endtask

    task automatic test_seq_fetch();
        logic [7:0] exp_d [4];
        bit ok = 1'b0;
        exp_d = '{8'h5A, 8'h5B, 8'h58, 8'h59};
        issued_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            fetch_req  = 1'b1;
            fetch_addr = 16'(i);
            @(negedge clk);
            n_checks++;
            if (fetch_valid !== 1'b1 || fetch_data !== exp_d[i]) begin
                n_fail++;
                $display("FAIL seq_hit[%0d]: valid %0b data %h want 1 %h", i, fetch_valid, fetch_data,
                         exp_d[i]);
            end
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (issued_q.size() > 0) ok = 1'b1;
        end
        n_checks++;
        if (!ok || issued_q[0] !== 16'h0004) begin
            n_fail++; $display("FAIL refetch_addr: got %h want 0004", ok ? issued_q[0] : 16'hxxxx);
        end
        wait_full("refill_full");
    endtask

    task automatic test_jump();
        logic [15:0] exp_a [4];
        bit found = 1'b0;
        bit got   = 1'b0;
        exp_a = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = 16'h0010;
        @(negedge clk);
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL jump10_miss: valid %0b want 0", fetch_valid); end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        issued_q.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req && !mem_done && mem_addr == 16'h0013) begin
                resp_en = 1'b0;
                found   = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL jump_req13: no request for 0013 seen, required one"); end
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = 16'h0080;
        @(negedge clk);
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL jump80_miss: valid %0b want 0", fetch_valid); end
        for (int i = 0; i < 4 && i < issued_q.size(); i++) begin
            n_checks++;
            if (issued_q[i] !== exp_a[i]) begin
                n_fail++; $display("FAIL jump_fill[%0d]: got %h want %h", i, issued_q[i], exp_a[i]);
            end
        end
        @(negedge clk);
        issued_q.delete();
        kick_req = kick_req + 1;
        resp_en  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_done && mem_addr == 16'h0080) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL jump80_return: no return for 0080 seen, required one"); end
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass: valid %0b want 0", fetch_valid); end
        n_checks++;
        if (issued_q.size() == 0 || issued_q[0] !== 16'h0080) begin
            n_fail++; $display("FAIL jump_first_addr: got %h want 0080",
                               issued_q.size() > 0 ? issued_q[0] : 16'hxxxx);
        end
        @(negedge clk);
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_data !== 8'hDA) begin
            n_fail++; $display("FAIL jump80_hit: valid %0b data %h want 1 da", fetch_valid, fetch_data);
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        wait_full("jump_refill");
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a [4];
        logic [7:0]  exp_d [4];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        exp_d = '{8'h5B, 8'h5A, 8'h5A, 8'h5B};
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = 16'hFFFE;
        @(negedge clk);
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_miss: valid %0b want 0", fetch_valid); end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        issued_q.delete();
        wait_full("wrap_full");
        n_checks++;
        if (issued_q.size() != 4) begin
            n_fail++; $display("FAIL wrap_count: got %0d requests want 4", issued_q.size());
        end
        for (int i = 0; i < 4 && i < issued_q.size(); i++) begin
            n_checks++;
            if (issued_q[i] !== exp_a[i]) begin
                n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, issued_q[i], exp_a[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            fetch_req  = 1'b1;
            fetch_addr = exp_a[i];
            @(negedge clk);
            n_checks++;
            if (fetch_valid !== 1'b1 || fetch_data !== exp_d[i]) begin
                n_fail++;
                $display("FAIL wrap_hit[%0d]: valid %0b data %h want 1 %h", i, fetch_valid, fetch_data,
                         exp_d[i]);
            end
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
    endtask

    task automatic test_done_flush();
        bit found = 1'b0;
        resp_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req && !mem_done) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL df_req: mem_req never rose, required 1"); end
        kick_req = kick_req + 1;
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = 16'h0200;
        @(negedge clk);
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL df_miss: valid %0b want 0", fetch_valid); end
        @(posedge clk); #1;
        fetch_req = 1'b0;
        resp_en   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL df_gap: mem_req %0b want 0", mem_req); end
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin
            n_fail++; $display("FAIL df_reissue: req %0b addr %h want 1 0200", mem_req, mem_addr);
        end
        wait_full("df_full");
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = 16'h0200;
        resp_en    = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_data !== 8'h58) begin
            n_fail++; $display("FAIL df_hit: valid %0b data %h want 1 58", fetch_valid, fetch_data);
        end
        @(posedge clk); #1;
        fetch_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rm_req: mem_req never rose, required 1"); end
        fetch_req  = 1'b1;
        fetch_addr = 16'h0201;
        #1;
        n_checks++;
        if (fetch_valid !== 1'b1 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rm_pre: valid %0b req %0b want 1 1", fetch_valid, mem_req);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || fetch_valid !== 1'b0 || mem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL rm_async: req %0b valid %0b addr %h want 0 0 0000", mem_req, fetch_valid,
                     mem_addr);
        end
        fetch_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        resp_en = 1'b1;
        issued_q.delete();
        wait_full("rm_refill");
        n_checks++;
        if (issued_q.size() == 0 || issued_q[0] !== 16'h0000) begin
            n_fail++; $display("FAIL rm_first_addr: got %h want 0000",
                               issued_q.size() > 0 ? issued_q[0] : 16'hxxxx);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_seq_fetch();
        test_jump();
        test_wrap();
        test_done_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_prefetch.md
Name: rom_prefetch

Overview:
Sequential instruction-byte prefetch queue between the CPU fetch path and the SPI memory controller's ROM read port. While the CPU executes, it fetches upcoming ROM bytes over the single-outstanding SPI request handshake into a small FIFO. In-order fetches are served with zero wait cycles. A fetch to any other address (jump or branch) flushes the queue and restarts prefetch from that address.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
AW, 16, address width (matches pc)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  CPU requests the byte at fetch_addr (level)
fetch_addr  in  AW  CPU program counter
fetch_valid  out  1  fetch_data valid this cycle; head entry consumed
fetch_data  out  8  instruction byte
mem_req  out  1  request to SPI controller (level, held until mem_done)
mem_addr  out  AW  ROM address; stable while mem_req=1
mem_done  in  1  one-cycle pulse; mem_data valid
mem_data  in  8  byte returned by SPI controller
busy  out  1  mem_req=1 or FIFO not full

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: FIFO empty, next_addr=0, mem_req=0, mem_addr=0, fetch_valid=0, fetch_data=0, stale=0, state=IDLE.
- FIFO entries: {addr[AW-1:0], data[7:0]}. rd_ptr/wr_ptr are log2(DEPTH) bits. Count is log2(DEPTH)+1 bits.
- Hit: fetch_req=1, FIFO non-empty, head.addr==fetch_addr.
  - fetch_valid=1 and fetch_data=head.data, combinationally in the same cycle.
  - Head is popped at the next clk edge.
- Miss: fetch_req=1 and not a hit.
  - fetch_valid=0.
  - If FIFO non-empty, or an outstanding request's address differs from fetch_addr: flush at the next edge (count:=0, next_addr:=fetch_addr). If mem_req=1, set stale:=1.
  - If FIFO is empty and the outstanding mem_addr==fetch_addr: no flush; wait for the data.
- FSM:
  - IDLE: if count<DEPTH, then mem_addr:=next_addr, next_addr:=next_addr+1 (wraps 0xFFFF->0x0000), mem_req:=1, go to WAIT. A flush in the same cycle overrides: next cycle issues from the new address.
  - WAIT: hold mem_req/mem_addr. On mem_done: mem_req:=0, go to IDLE. If stale=0, push {mem_addr, mem_data}; if stale=1, discard and clear stale.
- Occupancy: outstanding request counts toward occupancy, so a push never overflows. Issue only when count+(mem_req?1:0)<DEPTH.
- Simultaneous events:
  - Push and pop in the same cycle: both happen, count unchanged.
  - mem_done and flush in the same cycle: data discarded, no push, stale stays 0, FSM returns to IDLE.
  - Pop of the only entry while a push arrives: the pushed entry becomes head next cycle.
- Throughput: back-to-back requests. A new mem_req rises the cycle after mem_done.
- Hit on the byte arriving this cycle: not allowed. Data is served from the FIFO one cycle after mem_done (bypass-free).
- Reset mid-transaction: mem_req drops immediately. The SPI controller is reset by the same rst_n.
- busy=0 only when the FIFO is full and idle.

Optional Feature:
PREFETCH_STATS_EN. When defined, adds outputs hit_cnt[15:0] and flush_cnt[15:0].
- Both are saturating counters, reset to 0.
- hit_cnt increments on each hit cycle.
- flush_cnt increments on each flush.
- Without the macro, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset release, fetch_req=0, mem_done 2 cycles after each mem_req -> mem_addr sequence 0x0000,0x0001,0x0002,0x0003, then mem_req stays 0 (FIFO full, DEPTH=4).
- FIFO full with 0x00..0x03, fetch_addr 0..3 in consecutive cycles -> fetch_valid=1 four cycles with matching data; refetch resumes at 0x0004.
- Jump: FIFO holding 0x10..0x12, request for 0x13 outstanding, fetch_addr=0x80 -> fetch_valid=0, flush; the 0x13 return is discarded; next mem_addr=0x0080; fetch_valid=1 one cycle after 0x80 data returns.
- Wrap: after a jump to 0xFFFE, fill -> mem_addr 0xFFFE,0xFFFF,0x0000,0x0001; sequential fetch across 0xFFFF->0x0000 has no miss.
- mem_done coincident with a flush to 0x0200 -> no push; next mem_addr=0x0200 with mem_req rising the following cycle.
- rst_n low while mem_req=1 -> mem_req=0, fetch_valid=0 asynchronously; after release, first mem_addr=0x0000.
